ts_usb_in_sched: RTL and testbench

Scheduler that shares the single USB EP3 IN buffer between two TS byte FIFOs: req0 is the main TS FIFO and req1 is the CAM/aux FIFO.
- Moves whole 188-byte TS packets into the endpoint buffer.
- Each commit carries packets from one source only.
- Issues the commit and waits for the acknowledge or a timeout.
- Grants the two sources round-robin, per commit.
- Sits between the TS FIFOs and the EP3 IN buffer, replacing the single-source sampler.

---
 rtl/ts_sched_pkg.sv | 18 +
 rtl/ts_usb_in_sched_if.sv | 23 ++
 rtl/rr_arb2.sv | 21 ++
 rtl/ts_usb_in_sched.sv | 186 ++++++++++++++++++
 tb/tb_ts_usb_in_sched.sv | 354 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ts_sched_pkg.sv
// Shared types and constants for the EP3 IN scheduler: FSM states, TS packet
// geometry and the buffer address/length width.
package ts_sched_pkg;

  localparam int         TS_PKT_LEN   = 188;
  localparam logic [7:0] TS_SYNC_BYTE = 8'h47;
  localparam int         TS_AW        = 11;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_XFER     = 3'd1,
    ST_DRAIN    = 3'd2,
    ST_HOLD     = 3'd3,
    ST_COMMIT   = 3'd4,
    ST_WAIT_ACK = 3'd5
  } sched_state_e;

endpackage

// File: rtl/ts_usb_in_sched_if.sv
// EP3 IN buffer port: byte write side, commit handshake and buffer-free flag.
interface ts_usb_in_sched_if;
  import ts_sched_pkg::*;

  logic [TS_AW-1:0] usb_in_addr;
  logic [7:0]       usb_in_data;
  logic             usb_in_wren;
  logic             usb_in_commit;
  logic [TS_AW-1:0] usb_in_commit_len;
  logic             usb_in_ready;
  logic             usb_in_commit_ack;

  modport master (
    output usb_in_addr, usb_in_data, usb_in_wren, usb_in_commit, usb_in_commit_len,
    input  usb_in_ready, usb_in_commit_ack
  );

  modport slave (
    input  usb_in_addr, usb_in_data, usb_in_wren, usb_in_commit, usb_in_commit_len,
    output usb_in_ready, usb_in_commit_ack
  );

endinterface

// File: rtl/rr_arb2.sv
// Two-requester round-robin arbiter; the pointer moves only when a commit is
// released, so it favours the source that did not own the last commit.
module rr_arb2 (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] i_req,
  input  logic       i_update,
  input  logic       i_last,
  output logic       o_grant
);

  logic r_ptr;

  always_ff @(posedge clk) begin
    if (reset)         r_ptr <= 1'b0;
    else if (i_update) r_ptr <= ~i_last;
  end

  assign o_grant = i_req[r_ptr] ? r_ptr : ~r_ptr;

endmodule

// File: rtl/ts_usb_in_sched.sv
// Packs whole TS packets from two FIFOs into the EP3 IN buffer, one source per
// commit, round-robin per commit. Define TS_SYNC_CHECK_EN to count bad sync bytes.
module ts_usb_in_sched
  import ts_sched_pkg::*;
#(
  parameter int PKT_LEN       = TS_PKT_LEN,
  parameter int ACK_TIMEOUT   = 64,
  parameter int FLUSH_TIMEOUT = 4096
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [14:0]       i_req0_usedw,
  input  logic [7:0]        i_req0_q,
  output logic              o_req0_rdreq,
  input  logic [14:0]       i_req1_usedw,
  input  logic [7:0]        i_req1_q,
  output logic              o_req1_rdreq,
  input  logic [TS_AW-1:0]  i_max_len,
  ts_usb_in_sched_if.master ep3,
  output logic              o_grant,
  output logic [2:0]        o_state,
  output logic [15:0]       o_commits,
  output logic [8:0]        o_missed_ack,
  output logic [8:0]        o_sync_err
);

  localparam int MAX_PKTS = ((1 << TS_AW) - 1) / PKT_LEN;
  localparam int PW       = $clog2(PKT_LEN);
  localparam int AT       = $clog2(ACK_TIMEOUT) + 1;
  localparam int FW       = $clog2(FLUSH_TIMEOUT) + 1;

  sched_state_e     r_state;
  logic             r_grant, r_rd0, r_rd1, r_wren, r_commit;
  logic [TS_AW-1:0] r_addr, r_fill, r_commit_len;
  logic [PW-1:0]    r_byte;
  logic [AT-1:0]    r_ack_tmr;
  logic [FW-1:0]    r_idle;
  logic [2:0]       r_ack_s;
  logic [15:0]      r_commits;
  logic [8:0]       r_missed;

  logic [TS_AW-1:0] w_cap;
  logic [1:0]       w_elig;
  logic             w_pick, w_full, w_ack_rise, w_release;
  logic [7:0]       w_data_sel;

  // Largest whole-packet multiple that fits in the host-configured buffer.
  always_comb begin
    w_cap = '0;
    for (int k = 1; k <= MAX_PKTS; k++)
      if (int'(i_max_len) >= k * PKT_LEN) w_cap = TS_AW'(k * PKT_LEN);
  end

  assign w_elig[0]  = i_req0_usedw >= 15'(PKT_LEN);
  assign w_elig[1]  = i_req1_usedw >= 15'(PKT_LEN);
  assign w_full     = ({1'b0, r_fill} + (TS_AW+1)'(PKT_LEN)) > {1'b0, w_cap};
  assign w_ack_rise = r_ack_s[1] & ~r_ack_s[2];
  assign w_release  = (r_state == ST_WAIT_ACK) &&
                      (w_ack_rise || r_ack_tmr == AT'(ACK_TIMEOUT - 1));
  assign w_data_sel = r_grant ? i_req1_q : i_req0_q;

  rr_arb2 u_arb (
    .clk      (clk),
    .reset    (reset),
    .i_req    (w_elig),
    .i_update (w_release),
    .i_last   (r_grant),
    .o_grant  (w_pick)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_grant      <= 1'b0;
      r_rd0        <= 1'b0;
      r_rd1        <= 1'b0;
      r_wren       <= 1'b0;
      r_commit     <= 1'b0;
      r_addr       <= '0;
      r_fill       <= '0;
      r_commit_len <= '0;
      r_byte       <= '0;
      r_ack_tmr    <= '0;
      r_idle       <= '0;
      r_ack_s      <= '0;
      r_commits    <= '0;
      r_missed     <= '0;
    end else begin
      r_ack_s <= {r_ack_s[1:0], ep3.usb_in_commit_ack};
      r_wren  <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (ep3.usb_in_ready && w_cap >= TS_AW'(PKT_LEN) && |w_elig) begin
            r_grant <= w_pick;
            r_fill  <= '0;
            r_byte  <= '0;
            r_rd0   <= ~w_pick;
            r_rd1   <= w_pick;
            r_state <= ST_XFER;
          end
        end
        // Write address lags the read strobe by one cycle, matching FIFO latency.
        ST_XFER: begin
          r_wren <= 1'b1;
          r_addr <= r_fill + TS_AW'(r_byte);
          r_byte <= r_byte + 1'b1;
          if (r_byte == PW'(PKT_LEN - 1)) begin
            r_rd0   <= 1'b0;
            r_rd1   <= 1'b0;
            r_state <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          r_fill  <= r_fill + TS_AW'(PKT_LEN);
          r_idle  <= '0;
          r_state <= ST_HOLD;
        end
        ST_HOLD: begin
          if (w_full || r_idle == FW'(FLUSH_TIMEOUT - 1)) begin
            r_commit     <= 1'b1;
            r_commit_len <= r_fill;
            r_ack_tmr    <= '0;
            r_state      <= ST_COMMIT;
          end else if (w_elig[r_grant]) begin
            r_byte  <= '0;
            r_rd0   <= ~r_grant;
            r_rd1   <= r_grant;
            r_state <= ST_XFER;
          end else begin
            r_idle <= r_idle + 1'b1;
          end
        end
        ST_COMMIT: begin
          r_ack_tmr <= r_ack_tmr + 1'b1;
          r_state   <= ST_WAIT_ACK;
        end
        ST_WAIT_ACK: begin
          if (w_release) begin
            r_commit     <= 1'b0;
            r_commit_len <= '0;
            r_commits    <= r_commits + 1'b1;
            if (!w_ack_rise) r_missed <= r_missed + 1'b1;
            r_state      <= ST_IDLE;
          end else begin
            r_ack_tmr <= r_ack_tmr + 1'b1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

`ifdef TS_SYNC_CHECK_EN
  logic       r_first;
  logic [8:0] r_sync_err;

  // r_first marks the write cycle carrying byte 0 of a packet.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_first    <= 1'b0;
      r_sync_err <= '0;
    end else begin
      r_first <= (r_state == ST_XFER) && (r_byte == '0);
      if (r_wren && r_first && w_data_sel != TS_SYNC_BYTE)
        r_sync_err <= r_sync_err + 1'b1;
    end
  end

  assign o_sync_err = r_sync_err;
`else
  assign o_sync_err = '0;
`endif

  assign o_req0_rdreq          = r_rd0;
  assign o_req1_rdreq          = r_rd1;
  assign o_grant               = r_grant;
  assign o_state               = r_state;
  assign o_commits             = r_commits;
  assign o_missed_ack          = r_missed;
  assign ep3.usb_in_addr       = r_addr;
  assign ep3.usb_in_data       = r_wren ? w_data_sel : 8'h00;
  assign ep3.usb_in_wren       = r_wren;
  assign ep3.usb_in_commit     = r_commit;
  assign ep3.usb_in_commit_len = r_commit_len;

endmodule

// File: tb/tb_ts_usb_in_sched.sv
// Randomized bench for ts_usb_in_sched: FIFO byte-stream model, buffer write
// scoreboard and commit/round-robin reference.
module tb_ts_usb_in_sched;

  localparam int PKT      = 188;
  localparam int FLUSH_TO = 4096;
`ifdef TS_SYNC_CHECK_EN
  localparam int EXP_SERR = 1;
`else
  localparam int EXP_SERR = 0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        fifo_clr = 1'b1;
  logic [14:0] usedw0, usedw1;
  logic [7:0]  q0 = '0, q1 = '0;
  logic        rd0, rd1, grant;
  logic [10:0] max_len = '0;
  logic [2:0]  state;
  logic [15:0] commits;
  logic [8:0]  missed, serr;

  always #5 clk = ~clk;

  ts_usb_in_sched_if ep3 ();

  ts_usb_in_sched dut (
    .clk          (clk),
    .reset        (reset),
    .i_req0_usedw (usedw0),
    .i_req0_q     (q0),
    .o_req0_rdreq (rd0),
    .i_req1_usedw (usedw1),
    .i_req1_q     (q1),
    .o_req1_rdreq (rd1),
    .i_max_len    (max_len),
    .ep3          (ep3),
    .o_grant      (grant),
    .o_state      (state),
    .o_commits    (commits),
    .o_missed_ack (missed),
    .o_sync_err   (serr)
  );

  int checks = 0, failures = 0;

  // FIFO model: each source is a byte stream; usedw = bytes supplied - bytes read.
  logic [7:0] tab [0:1][0:8191];
  int avail [2] = '{0, 0};
  int rc    [2] = '{0, 0};

  function automatic logic [14:0] lvl(input int a, input int r);
    int d;
    d = a - r;
    if (d < 0) d = 0;
    if (d > 32767) d = 32767;
    return 15'(d);
  endfunction

  assign usedw0 = lvl(avail[0], rc[0]);
  assign usedw1 = lvl(avail[1], rc[1]);

  always @(posedge clk) begin
    if (fifo_clr) begin
      rc[0] <= 0;
      rc[1] <= 0;
    end else begin
      if (rd0) begin q0 <= tab[0][rc[0] % 8192]; rc[0] <= rc[0] + 1; end
      if (rd1) begin q1 <= tab[1][rc[1] % 8192]; rc[1] <= rc[1] + 1; end
    end
  end

  // Buffer/commit monitor, sampled on the falling edge.
  logic [10:0] wa [0:4095];
  logic [7:0]  wd [0:4095];
  int wcount = 0, cyc = 0, lastw = 0, ncm = 0, hicnt = 0, both_rd = 0;
  int cm_len [0:15], cm_gnt [0:15], cm_gap [0:15], cm_hi [0:15];
  logic cprev = 1'b0;

  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (fifo_clr) begin
      wcount <= 0; ncm <= 0; cprev <= 1'b0; hicnt <= 0; both_rd <= 0;
    end else begin
      if (ep3.usb_in_wren) begin
        wa[wcount % 4096] <= ep3.usb_in_addr;
        wd[wcount % 4096] <= ep3.usb_in_data;
        wcount <= wcount + 1;
        lastw  <= cyc;
      end
      if (rd0 && rd1) both_rd <= both_rd + 1;
      cprev <= ep3.usb_in_commit;
      if (ep3.usb_in_commit && !cprev) begin
        cm_len[ncm % 16] <= int'(ep3.usb_in_commit_len);
        cm_gnt[ncm % 16] <= int'(grant);
        cm_gap[ncm % 16] <= cyc - lastw;
        ncm   <= ncm + 1;
        hicnt <= 1;
      end else if (ep3.usb_in_commit) begin
        hicnt <= hicnt + 1;
      end
      if (!ep3.usb_in_commit && cprev) cm_hi[(ncm - 1) % 16] <= hicnt;
    end
  end

  int wbase = 0, cm_rd = 0;
  int exp_base [2] = '{0, 0};

  task automatic do_reset();
    reset = 1'b1; fifo_clr = 1'b1;
    avail[0] = 0; avail[1] = 0;
    ep3.usb_in_commit_ack = 1'b0;
    ep3.usb_in_ready = 1'b1;
    for (int s = 0; s < 2; s++)
      for (int n = 0; n < 8192; n++)
        tab[s][n] = (n % PKT == 0) ? 8'h47 : 8'($urandom);
    repeat (2) @(negedge clk);
    reset = 1'b0; fifo_clr = 1'b0;
    wbase = 0; cm_rd = 0;
    exp_base[0] = 0; exp_base[1] = 0;
  endtask

  // Waits for the next commit, then scores the bytes written since the last one
  // against the granted source's stream (nbad = bad address/data/count).
  task automatic wait_commit(output bit got, output int len, output int gnt,
                             output int nbad, output int gap, output logic [7:0] fdata);
    got = 0; len = 0; gnt = 0; nbad = 0; gap = 0; fdata = '0;
    for (int i = 0; i < 12000; i++) begin
      if (ncm > cm_rd) begin got = 1; break; end
      @(negedge clk);
    end
    if (got) begin
      len = cm_len[cm_rd % 16];
      gnt = cm_gnt[cm_rd % 16];
      gap = cm_gap[cm_rd % 16];
      cm_rd++;
      if (wcount - wbase != len) nbad++;
      for (int i = 0; i < len; i++)
        if (int'(wa[(wbase + i) % 4096]) != i ||
            wd[(wbase + i) % 4096] != tab[gnt][(exp_base[gnt] + i) % 8192]) nbad++;
      fdata = wd[wbase % 4096];
      exp_base[gnt] += len;
      wbase = wcount;
    end
  endtask

  task automatic ack_it(input int dly, output bit dropped);
    repeat (dly) @(negedge clk);
    ep3.usb_in_commit_ack = 1'b1;
    repeat (2) @(negedge clk);
    ep3.usb_in_commit_ack = 1'b0;
    dropped = 0;
    for (int i = 0; i < 20; i++) begin
      if (!ep3.usb_in_commit) begin dropped = 1; break; end
      @(negedge clk);
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    logic [63:0] outs;
    do_reset();
    max_len = 11'd1504;
    repeat (3) @(negedge clk);
    outs = {rd0, rd1, ep3.usb_in_wren, ep3.usb_in_addr, ep3.usb_in_data, ep3.usb_in_commit,
            ep3.usb_in_commit_len, grant, commits, missed, serr};
    checks++;
    if (outs !== '0) begin failures++; $display("FAIL reset_outputs got=%h exp=0", outs); end
    checks++;
    if (state !== 3'd0) begin failures++; $display("FAIL reset_state got=%0d exp=0", state); end
    repeat (20) @(negedge clk);
    checks++;
    if (rc[0] + rc[1] != 0 || state !== 3'd0) begin
      failures++; $display("FAIL idle_no_source reads=%0d state=%0d exp 0/0", rc[0] + rc[1], state);
    end
  endtask

  task automatic test_single();
    bit got, dr; int len, gnt, nbad, gap; logic [7:0] fd;
    do_reset();
    max_len = 11'd1504; avail[0] = 100000;
    wait_commit(got, len, gnt, nbad, gap, fd);
    checks++;
    if (!got || len != 1504) begin failures++; $display("FAIL single_len got=%0d exp=1504", len); end
    checks++;
    if (gnt != 0) begin failures++; $display("FAIL single_grant got=%0d exp=0", gnt); end
    checks++;
    if (nbad != 0) begin failures++; $display("FAIL single_data bad=%0d exp=0", nbad); end
    checks++;
    if (rc[0] != 1504 || rc[1] != 0) begin
      failures++; $display("FAIL single_reads got=%0d/%0d exp=1504/0", rc[0], rc[1]);
    end
    checks++;
    if (int'(serr) != 0) begin failures++; $display("FAIL single_sync got=%0d exp=0", serr); end
    ack_it(10, dr);
    checks++;
    if (!dr || commits !== 16'd1 || missed !== 9'd0) begin
      failures++; $display("FAIL single_ack dropped=%0d commits=%0d missed=%0d exp 1/1/0", dr, commits, missed);
    end
  endtask

  task automatic test_round_robin();
    bit got, dr; int len, gnt, nbad, gap, ptr, eg; logic [7:0] fd;
    do_reset();
    max_len = 11'(376 + $urandom_range(0, 187));
    avail[0] = 100000; avail[1] = 100000;
    ptr = 0;
    for (int k = 0; k < 4; k++) begin
      wait_commit(got, len, gnt, nbad, gap, fd);
      eg = ptr;
      checks++;
      if (!got || gnt != eg || len != 376 || nbad != 0) begin
        failures++;
        $display("FAIL rr_commit%0d grant=%0d len=%0d bad=%0d exp grant=%0d len=376 bad=0", k, gnt, len, nbad, eg);
      end
      ack_it(k == 0 ? 10 : int'($urandom_range(3, 15)), dr);
      checks++;
      if (!dr) begin failures++; $display("FAIL rr_ack%0d commit still high", k); end
      ptr = 1 - eg;
    end
    checks++;
    if (commits !== 16'd4 || missed !== 9'd0 || both_rd != 0) begin
      failures++; $display("FAIL rr_counts commits=%0d missed=%0d both=%0d exp 4/0/0", commits, missed, both_rd);
    end
  endtask

  task automatic test_flush();
    bit got, dr; int len, gnt, nbad, gap; logic [7:0] fd;
    do_reset();
    max_len = 11'd1504; avail[0] = 476;
    wait_commit(got, len, gnt, nbad, gap, fd);
    checks++;
    if (!got || len != 376 || nbad != 0) begin
      failures++; $display("FAIL flush_len got=%0d bad=%0d exp 376/0", len, nbad);
    end
    checks++;
    if (gap < FLUSH_TO || gap > FLUSH_TO + 3) begin
      failures++; $display("FAIL flush_delay got=%0d exp %0d..%0d", gap, FLUSH_TO, FLUSH_TO + 3);
    end
    ack_it(5, dr);
  endtask

  task automatic test_ack_timeout();
    bit got, dropped; int len, gnt, nbad, gap; logic [7:0] fd; logic [2:0] st;
    do_reset();
    max_len = 11'd188; avail[0] = 100000;
    wait_commit(got, len, gnt, nbad, gap, fd);
    checks++;
    if (!got || len != 188 || nbad != 0) begin
      failures++; $display("FAIL to_commit len=%0d bad=%0d exp 188/0", len, nbad);
    end
    dropped = 0; st = '1;
    for (int i = 0; i < 200; i++) begin
      if (!ep3.usb_in_commit) begin dropped = 1; st = state; break; end
      @(negedge clk);
    end
    @(negedge clk);
    checks++;
    if (!dropped || cm_hi[0] != 64) begin
      failures++; $display("FAIL to_duration got=%0d exp=64", cm_hi[0]);
    end
    checks++;
    if (missed !== 9'd1 || commits !== 16'd1 || st !== 3'd0) begin
      failures++; $display("FAIL to_counts missed=%0d commits=%0d state=%0d exp 1/1/0", missed, commits, st);
    end
  endtask

  task automatic test_reset_mid();
    bit got, dr, hit; int len, gnt, nbad, gap; logic [7:0] fd; logic [63:0] outs;
    do_reset();
    max_len = 11'd1504; avail[0] = 100000;
    hit = 0;
    for (int i = 0; i < 1000; i++) begin
      if (wcount >= 90) begin hit = 1; break; end
      @(negedge clk);
    end
    reset = 1'b1;
    @(negedge clk);
    outs = {rd0, rd1, ep3.usb_in_wren, ep3.usb_in_addr, ep3.usb_in_data, ep3.usb_in_commit,
            ep3.usb_in_commit_len, grant, commits, missed, serr};
    checks++;
    if (!hit || outs !== '0 || state !== 3'd0) begin
      failures++; $display("FAIL midreset_outputs got=%h state=%0d exp 0/0", outs, state);
    end
    reset = 1'b0;
    @(negedge clk);
    exp_base[0] = rc[0];
    wbase = wcount;
    wait_commit(got, len, gnt, nbad, gap, fd);
    checks++;
    if (!got || len != 1504 || nbad != 0) begin
      failures++; $display("FAIL midreset_next len=%0d bad=%0d exp 1504/0", len, nbad);
    end
    ack_it(4, dr);
  endtask

  task automatic test_sync();
    bit got, dr; int len, gnt, nbad, gap; logic [7:0] fd;
    do_reset();
    tab[0][0] = 8'h46;
    max_len = 11'd188; avail[0] = 100000;
    wait_commit(got, len, gnt, nbad, gap, fd);
    checks++;
    if (!got || fd !== 8'h46 || nbad != 0) begin
      failures++; $display("FAIL sync_data first=%h bad=%0d exp 46/0", fd, nbad);
    end
    checks++;
    if (int'(serr) != EXP_SERR) begin failures++; $display("FAIL sync_err got=%0d exp=%0d", serr, EXP_SERR); end
    ack_it(6, dr);
  endtask

  task automatic test_cap();
    bit got, dr; int len, gnt, nbad, gap, v, exp_len; logic [7:0] fd;
    int vals [4];
    vals = '{187, 188, 375, int'($urandom_range(376, 2047))};
    for (int t = 0; t < 4; t++) begin
      v = vals[t];
      exp_len = (v / PKT) * PKT;
      do_reset();
      max_len = 11'(v); avail[0] = 100000;
      if (exp_len == 0) begin
        repeat (300) @(negedge clk);
        checks++;
        if (rc[0] != 0 || state !== 3'd0) begin
          failures++; $display("FAIL cap_small max=%0d reads=%0d state=%0d exp 0/0", v, rc[0], state);
        end
      end else begin
        wait_commit(got, len, gnt, nbad, gap, fd);
        checks++;
        if (!got || len != exp_len || nbad != 0) begin
          failures++; $display("FAIL cap_len max=%0d got=%0d bad=%0d exp=%0d", v, len, nbad, exp_len);
        end
        ack_it(int'($urandom_range(2, 12)), dr);
      end
    end
  endtask

  initial begin
    ep3.usb_in_ready = 1'b0;
    ep3.usb_in_commit_ack = 1'b0;
    test_reset();
    test_single();
    test_round_robin();
    test_flush();
    test_ack_timeout();
    test_reset_mid();
    test_sync();
    test_cap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
